// File: rtl/abacus_pkg.sv
// ABACUS counter bank shared definitions.
// Register offsets, control bit positions and size limits.
package abacus_pkg;

    localparam int MAX_COUNTERS = 32;
    localparam int MAX_EVENTS   = 256;

    localparam logic [11:0] OFF_CTRL       = 12'h000;
    localparam logic [11:0] OFF_OVF_STATUS = 12'h004;
    localparam logic [11:0] OFF_OVF_IRQ_EN = 12'h008;
    localparam logic [11:0] OFF_SEL_BASE   = 12'h100;
    localparam logic [11:0] OFF_CNT_BASE   = 12'h200;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;
    localparam int SEL_EN_BIT   = 31;
    localparam int SEL_IDX_W    = 8;

endpackage

// File: rtl/abacus_event_counter.sv
// ABACUS single event counter.
// Event select, increment with wrap detect, LO/HI preload and clear.
module abacus_event_counter
    import abacus_pkg::*;
#(
    parameter int NUM_EVENTS    = 16,
    parameter int COUNTER_WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_EVENTS-1:0]    events_i,
    input  logic                     global_en_i,
    input  logic                     clr_i,
    input  logic                     sel_we_i,
    input  logic                     lo_we_i,
    input  logic                     hi_we_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              sel_o,
    output logic [COUNTER_WIDTH-1:0] cnt_o,
    output logic                     wrap_o
);

    localparam int HW = COUNTER_WIDTH - 32;

    logic                     sel_en_q;
    logic [SEL_IDX_W-1:0]     sel_idx_q;
    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [COUNTER_WIDTH-1:0] cnt_d;
    logic [MAX_EVENTS-1:0]    ev_ext;
    logic                     hit;

    // Zero-extended so that selects beyond NUM_EVENTS never count.
    assign ev_ext = MAX_EVENTS'(events_i);
    assign hit    = global_en_i & sel_en_q & ev_ext[sel_idx_q];

    always_comb begin
        cnt_d  = cnt_q;
        wrap_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (lo_we_i) begin
            cnt_d[31:0] = wdata_i;
        end else if (hi_we_i) begin
            cnt_d[COUNTER_WIDTH-1:32] = wdata_i[HW-1:0];
        end else if (hit) begin
            cnt_d  = cnt_q + COUNTER_WIDTH'(1);
            wrap_o = &cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_en_q  <= 1'b0;
            sel_idx_q <= '0;
            cnt_q     <= '0;
        end else begin
            if (sel_we_i) begin
                sel_en_q  <= wdata_i[SEL_EN_BIT];
                sel_idx_q <= wdata_i[SEL_IDX_W-1:0];
            end
            cnt_q <= cnt_d;
        end
    end

    assign sel_o = {sel_en_q, {(31-SEL_IDX_W){1'b0}}, sel_idx_q};
    assign cnt_o = cnt_q;

endmodule

// File: rtl/abacus_counter_bank.sv
// ABACUS profiler counter bank, Wishbone slave.
// Bus decode, CTRL/OVF registers, coherent-read shadow and read mux.
module abacus_counter_bank
    import abacus_pkg::*;
#(
    parameter int          NUM_COUNTERS  = 8,
    parameter int          NUM_EVENTS    = 16,
    parameter int          COUNTER_WIDTH = 48,
    parameter logic [31:0] BASE_ADDR     = 32'hf0030400
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EVENTS-1:0] events,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic                  wb_we,
    input  logic [31:0]           wb_adr,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack,
    output logic                  irq
);

    localparam int N = NUM_COUNTERS;

    logic                     ack_q;
    logic [31:0]              dat_q;
    logic                     ctrl_en_q;
    logic [N-1:0]             ovf_status_q;
    logic [N-1:0]             ovf_status_d;
    logic [N-1:0]             ovf_irq_en_q;
    logic [31:0]              shadow_q;
    logic [31:0]              shadow_d;
    logic [31:0]              rdata;

    logic [COUNTER_WIDTH-1:0] cnt_arr [N];
    logic [31:0]              sel_arr [N];
    logic [N-1:0]             wrap_vec;

    logic        req, wr, rd;
    logic [31:0] off;
    logic        in_win;
    logic        is_ctrl, is_stat, is_irqen, is_sel, is_cnt;
    logic [4:0]  sel_idx, cnt_idx;
    logic        cnt_hi;
    logic        clr_all;

    assign req = wb_cyc & wb_stb & ~ack_q;
    assign wr  = req & wb_we;
    assign rd  = req & ~wb_we;

    // Offset by subtraction, so the base need not be window aligned.
    assign off    = wb_adr - BASE_ADDR;
    assign in_win = (off[31:12] == 20'h0) & (off[1:0] == 2'b00);

    assign is_ctrl  = in_win & (off[11:0] == OFF_CTRL);
    assign is_stat  = in_win & (off[11:0] == OFF_OVF_STATUS);
    assign is_irqen = in_win & (off[11:0] == OFF_OVF_IRQ_EN);
    assign is_sel   = in_win & (off[11:7] == OFF_SEL_BASE[11:7]);
    assign is_cnt   = in_win & (off[11:8] == OFF_CNT_BASE[11:8]);
    assign sel_idx  = off[6:2];
    assign cnt_idx  = off[7:3];
    assign cnt_hi   = off[2];
    assign clr_all  = wr & is_ctrl & wb_dat_i[CTRL_CLR_BIT];

    for (genvar i = 0; i < N; i++) begin : g_cnt
        logic sel_we, lo_we, hi_we;
        assign sel_we = wr & is_sel & (sel_idx == 5'(i));
        assign lo_we  = wr & is_cnt & (cnt_idx == 5'(i)) & ~cnt_hi;
        assign hi_we  = wr & is_cnt & (cnt_idx == 5'(i)) & cnt_hi;

        abacus_event_counter #(
            .NUM_EVENTS    (NUM_EVENTS),
            .COUNTER_WIDTH (COUNTER_WIDTH)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .events_i    (events),
            .global_en_i (ctrl_en_q),
            .clr_i       (clr_all),
            .sel_we_i    (sel_we),
            .lo_we_i     (lo_we),
            .hi_we_i     (hi_we),
            .wdata_i     (wb_dat_i),
            .sel_o       (sel_arr[i]),
            .cnt_o       (cnt_arr[i]),
            .wrap_o      (wrap_vec[i])
        );
    end

    always_comb begin
        rdata    = '0;
        shadow_d = shadow_q;
        unique case (1'b1)
            is_ctrl:  rdata = 32'(ctrl_en_q);
            is_stat:  rdata = 32'(ovf_status_q);
            is_irqen: rdata = 32'(ovf_irq_en_q);
            is_sel: begin
                for (int i = 0; i < N; i++)
                    if (sel_idx == 5'(i)) rdata = sel_arr[i];
            end
            is_cnt: begin
                for (int i = 0; i < N; i++) begin
                    if (cnt_idx == 5'(i)) begin
                        rdata = cnt_hi ? shadow_q : cnt_arr[i][31:0];
                        if (rd & ~cnt_hi)
                            shadow_d = 32'(cnt_arr[i][COUNTER_WIDTH-1:32]);
                    end
                end
            end
            default: ;
        endcase
    end

    // Hardware wrap set wins over a simultaneous W1C.
    always_comb begin
        ovf_status_d = ovf_status_q;
        if (wr & is_stat) ovf_status_d = ovf_status_d & ~wb_dat_i[N-1:0];
        ovf_status_d = ovf_status_d | wrap_vec;
        if (clr_all) ovf_status_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q        <= 1'b0;
            dat_q        <= '0;
            ctrl_en_q    <= 1'b0;
            ovf_status_q <= '0;
            ovf_irq_en_q <= '0;
            shadow_q     <= '0;
        end else begin
            ack_q <= req;
            if (req) dat_q <= wb_we ? '0 : rdata;
            if (wr & is_ctrl) ctrl_en_q <= wb_dat_i[CTRL_EN_BIT];
            if (wr & is_irqen) ovf_irq_en_q <= wb_dat_i[N-1:0];
            if (rd) shadow_q <= shadow_d;
            ovf_status_q <= ovf_status_d;
        end
    end

    assign wb_ack   = ack_q;
    assign wb_dat_o = dat_q;
    assign irq      = |(ovf_status_q & ovf_irq_en_q);

endmodule

// File: tb/tb_abacus_counter_bank.sv
// Self-checking bench for abacus_counter_bank.
// Directed register scenarios plus randomized counting against a model.
module tb_abacus_counter_bank;

    localparam int          N    = 8;
    localparam int          NE   = 16;
    localparam int          W    = 48;
    localparam logic [31:0] BASE = 32'hf0030400;
    localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NE-1:0] events = '0;
    logic          wb_cyc = 1'b0;
    logic          wb_stb = 1'b0;
    logic          wb_we = 1'b0;
    logic [31:0]   wb_adr = '0;
    logic [31:0]   wb_dat_i = '0;
    logic [31:0]   wb_dat_o;
    logic          wb_ack;
    logic          irq;

    int checks = 0;
    int failures = 0;
    int last_lat = 0;

    abacus_counter_bank #(
        .NUM_COUNTERS  (N),
        .NUM_EVENTS    (NE),
        .COUNTER_WIDTH (W),
        .BASE_ADDR     (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .events   (events),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack   (wb_ack),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic xfer(input logic we, input logic [11:0] off,
                        input logic [31:0] wd, output logic [31:0] rdv);
        int n;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = BASE + 32'(off); wb_dat_i = wd;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!wb_ack && n < 8);
        last_lat = n;
        rdv = wb_dat_o;
        if (!wb_ack) begin
            checks++; failures++;
            $display("FAIL bus_timeout off=%h got no ack, need ack", off);
        end
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wr(input logic [11:0] off, input logic [31:0] d);
        logic [31:0] dum;
        xfer(1'b1, off, d, dum);
    endtask

    task automatic rd(input logic [11:0] off, output logic [31:0] d);
        xfer(1'b0, off, 32'h0, d);
    endtask

    task automatic pulse(input int b, input int n);
        repeat (n) begin
            @(negedge clk); events = '0; events[b] = 1'b1;
            @(negedge clk); events = '0;
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        repeat (3) @(negedge clk);
        checks++;
        if (wb_ack !== 1'b0 || wb_dat_o !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs ack=%b dat=%h irq=%b need 0", wb_ack, wb_dat_o, irq);
        end
        rst = 1'b0;
        for (int a = 0; a < 3; a++) begin
            rd(12'(4 * a), d); checks++;
            if (d !== 32'h0) begin
                failures++; $display("FAIL reset_reg%0d got %h need 0", a, d);
            end
        end
        for (int i = 0; i < N; i++) begin
            rd(12'h100 + 12'(4 * i), d); checks++;
            if (d !== 32'h0) begin failures++; $display("FAIL reset_sel%0d got %h need 0", i, d); end
            rd(12'h200 + 12'(8 * i), d); checks++;
            if (d !== 32'h0) begin failures++; $display("FAIL reset_lo%0d got %h need 0", i, d); end
            rd(12'h204 + 12'(8 * i), d); checks++;
            if (d !== 32'h0) begin failures++; $display("FAIL reset_hi%0d got %h need 0", i, d); end
        end
        rd(12'h300, d); checks++;
        if (d !== 32'h0 || last_lat != 1) begin
            failures++; $display("FAIL unmapped_read got %h lat %0d need 0 lat 1", d, last_lat);
        end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %b need 0", irq); end
    endtask

    task automatic test_count;
        logic [31:0] d;
        wr(12'h100, 32'h80000003);
        wr(12'h000, 32'h1);
        pulse(3, 10);
        pulse(2, 5);
        rd(12'h200, d); checks++;
        if (d !== 32'd10) begin failures++; $display("FAIL count_lo0 got %0d need 10", d); end
        rd(12'h204, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL count_hi0 got %h need 0", d); end
        rd(12'h100, d); checks++;
        if (d !== 32'h80000003) begin failures++; $display("FAIL sel0_rb got %h need 80000003", d); end
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        wr(12'h104, 32'h80000005);
        wr(12'h20C, 32'h0000FFFF);
        wr(12'h208, 32'hFFFFFFFE);
        pulse(5, 3);
        rd(12'h208, d); checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL wrap_lo1 got %h need 1", d); end
        rd(12'h20C, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL wrap_hi1 got %h need 0", d); end
        rd(12'h004, d); checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL wrap_status got %h need 2", d); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_masked got %b need 0", irq); end
        wr(12'h008, 32'h2); checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_enabled got %b need 1", irq); end
        rd(12'h200, d); checks++;
        if (d !== 32'd10) begin failures++; $display("FAIL wrap_lo0_kept got %0d need 10", d); end
        wr(12'h004, 32'h2);
        rd(12'h004, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL w1c_status got %h need 0", d); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_cleared got %b need 0", irq); end
    endtask

    task automatic test_write_priority;
        logic [31:0] d;
        @(negedge clk); events = '0; events[3] = 1'b1;
        repeat (3) @(negedge clk);
        wr(12'h200, 32'h100);
        events = '0;
        rd(12'h200, d); checks++;
        if (d !== 32'h100) begin failures++; $display("FAIL write_wins got %h need 100", d); end
        @(negedge clk); events[3] = 1'b1;
        repeat (7) @(negedge clk);
        events = '0;
        rd(12'h200, d); checks++;
        if (d !== 32'h107) begin failures++; $display("FAIL resume_count got %h need 107", d); end
    endtask

    task automatic test_shadow;
        logic [31:0] d;
        wr(12'h204, 32'h0);
        wr(12'h200, 32'hFFFFFFFF);
        rd(12'h200, d); checks++;
        if (d !== 32'hFFFFFFFF) begin failures++; $display("FAIL shadow_lo got %h need ffffffff", d); end
        pulse(3, 6);
        rd(12'h204, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL shadow_hi got %h need 0", d); end
        rd(12'h200, d); checks++;
        if (d !== 32'h5) begin failures++; $display("FAIL shadow_lo2 got %h need 5", d); end
        rd(12'h204, d); checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL shadow_hi2 got %h need 1", d); end
    endtask

    task automatic test_bad_select;
        logic [31:0] d;
        wr(12'h108, 32'h800000FF);
        @(negedge clk); events = '1;
        repeat (100) @(negedge clk);
        events = '0;
        rd(12'h210, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL badsel_lo2 got %h need 0", d); end
        wr(12'h000, 32'h3);
        rd(12'h108, d); checks++;
        if (d !== 32'h800000FF) begin failures++; $display("FAIL clr_keeps_sel got %h need 800000ff", d); end
        rd(12'h000, d); checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL ctrl_rb got %h need 1", d); end
        rd(12'h200, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL clr_lo0 got %h need 0", d); end
        rd(12'h208, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL clr_lo1 got %h need 0", d); end
        rd(12'h008, d); checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL clr_keeps_irqen got %h need 2", d); end
    endtask

    task automatic test_unmapped;
        logic [31:0] d;
        wr(12'h300, 32'hDEADBEEF); checks++;
        if (last_lat != 1) begin failures++; $display("FAIL unmapped_wr_ack lat %0d need 1", last_lat); end
        rd(12'h300, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL unmapped_rd got %h need 0", d); end
        wr(12'h120, 32'h80000001);
        rd(12'h120, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL sel8_rd got %h need 0", d); end
        wr(12'h240, 32'h1234);
        rd(12'h240, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL cnt8_rd got %h need 0", d); end
        rd(12'h100, d); checks++;
        if (d !== 32'h80000003) begin failures++; $display("FAIL sel0_untouched got %h need 80000003", d); end
    endtask

    task automatic test_random;
        logic [63:0]   m_cnt [N];
        logic          m_en  [N];
        int            m_idx [N];
        logic [N-1:0]  m_ovf, m_irqen;
        logic [NE-1:0] ev;
        logic [31:0]   d;
        for (int r = 0; r < 3; r++) begin
            wr(12'h000, 32'h3);
            m_ovf = '0;
            m_irqen = N'($urandom);
            wr(12'h008, 32'(m_irqen));
            for (int i = 0; i < N; i++) begin
                m_en[i]  = ($urandom_range(0, 3) != 0);
                m_idx[i] = $urandom_range(0, 19);
                wr(12'h100 + 12'(4 * i), {m_en[i], 23'h0, 8'(m_idx[i])});
                if ($urandom_range(0, 1) == 1)
                    m_cnt[i] = MASK - 64'($urandom_range(0, 40));
                else
                    m_cnt[i] = 64'($urandom);
                wr(12'h204 + 12'(8 * i), 32'(m_cnt[i][W-1:32]));
                wr(12'h200 + 12'(8 * i), m_cnt[i][31:0]);
            end
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                ev = NE'($urandom);
                events = ev;
                for (int i = 0; i < N; i++) begin
                    if (m_en[i] && m_idx[i] < NE && ev[m_idx[i]]) begin
                        if (m_cnt[i] == MASK) begin
                            m_cnt[i] = 64'h0; m_ovf[i] = 1'b1;
                        end else begin
                            m_cnt[i] = m_cnt[i] + 64'd1;
                        end
                    end
                end
            end
            @(negedge clk); events = '0;
            for (int i = 0; i < N; i++) begin
                rd(12'h200 + 12'(8 * i), d); checks++;
                if (d !== m_cnt[i][31:0]) begin
                    failures++; $display("FAIL rnd%0d_lo%0d got %h need %h", r, i, d, m_cnt[i][31:0]);
                end
                rd(12'h204 + 12'(8 * i), d); checks++;
                if (d !== 32'(m_cnt[i][W-1:32])) begin
                    failures++; $display("FAIL rnd%0d_hi%0d got %h need %h", r, i, d, m_cnt[i][W-1:32]);
                end
            end
            rd(12'h004, d); checks++;
            if (d !== 32'(m_ovf)) begin
                failures++; $display("FAIL rnd%0d_status got %h need %h", r, d, m_ovf);
            end
            checks++;
            if (irq !== |(m_ovf & m_irqen)) begin
                failures++; $display("FAIL rnd%0d_irq got %b need %b", r, irq, |(m_ovf & m_irqen));
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = BASE + 32'h200;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        checks++;
        if (wb_ack !== 1'b0 || wb_dat_o !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid ack=%b dat=%h irq=%b need 0", wb_ack, wb_dat_o, irq);
        end
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; rst = 1'b0;
        rd(12'h100, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_mid_sel0 got %h need 0", d); end
    endtask

    initial begin
        test_reset;
        test_count;
        test_wrap;
        test_write_priority;
        test_shadow;
        test_bad_select;
        test_unmapped;
        test_random;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
